// File: rtl/traffic_phase_controller_pkg.sv
// Shared phase encoding, lamp codes and lamp decode for the intersection controller.
package traffic_phase_controller_pkg;

  localparam int unsigned PHASE_W = 3;
  localparam int unsigned LAMP_W  = 3;

  typedef enum logic [PHASE_W-1:0] {
    NS_G  = 3'd0,
    NS_Y  = 3'd1,
    RED_A = 3'd2,
    WALK  = 3'd3,
    EW_G  = 3'd4,
    EW_Y  = 3'd5,
    RED_B = 3'd6
  } phase_e;

  // One-hot {red,yellow,green}
  localparam logic [LAMP_W-1:0] LAMP_R = 3'b100;
  localparam logic [LAMP_W-1:0] LAMP_Y = 3'b010;
  localparam logic [LAMP_W-1:0] LAMP_G = 3'b001;

  typedef struct packed {
    logic [LAMP_W-1:0] ns;
    logic [LAMP_W-1:0] ew;
    logic              walk;
  } lamps_t;

  // Moore lamp decode; unknown encodings fall back to all-red.
  function automatic lamps_t lamp_decode(input phase_e p);
    lamps_t l;
    l.ns   = LAMP_R;
    l.ew   = LAMP_R;
    l.walk = 1'b0;
    case (p)
      NS_G:    l.ns   = LAMP_G;
      NS_Y:    l.ns   = LAMP_Y;
      EW_G:    l.ew   = LAMP_G;
      EW_Y:    l.ew   = LAMP_Y;
      WALK:    l.walk = 1'b1;
      default: ;
    endcase
    return l;
  endfunction

endpackage

// File: rtl/traffic_phase_controller_phase_timer.sv
// Down-counting phase timer: load wins over decrement, saturates at zero.
module phase_timer #(
  parameter int unsigned TIME_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  load,
  input  logic [TIME_WIDTH-1:0] load_val,
  output logic [TIME_WIDTH-1:0] time_left,
  output logic                  is_zero
);

  logic [TIME_WIDTH-1:0] cnt_q, cnt_d;

  // Next count: load on phase entry, otherwise tick down toward zero
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - TIME_WIDTH'(1);
    end
  end

  // Count register with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign time_left = cnt_q;
  assign is_zero   = (cnt_q == '0);

endmodule

// File: rtl/traffic_phase_controller.sv
// Two-road intersection sequencer with pedestrian phase and latched requests.
module traffic_phase_controller
  import traffic_phase_controller_pkg::*;
#(
  parameter int unsigned TIME_WIDTH = 6,
  parameter int unsigned GREEN_NS   = 30,
  parameter int unsigned GREEN_EW   = 20,
  parameter int unsigned YELLOW     = 4,
  parameter int unsigned ALL_RED    = 2,
  parameter int unsigned PED_WALK   = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  sensor_ew,
  input  logic                  ped_req,
  output logic [LAMP_W-1:0]     light_ns,
  output logic [LAMP_W-1:0]     light_ew,
  output logic                  walk,
  output logic [PHASE_W-1:0]    phase,
  output logic [TIME_WIDTH-1:0] time_left,
  output logic                  car_pending,
  output logic                  ped_pending
);

  localparam int unsigned DUR_MAX = 32'd1 << TIME_WIDTH;

  // Durations must be loadable as DUR-1 into the timer
  if (GREEN_NS < 1 || GREEN_NS > DUR_MAX || GREEN_EW < 1 || GREEN_EW > DUR_MAX ||
      YELLOW   < 1 || YELLOW   > DUR_MAX || ALL_RED  < 1 || ALL_RED  > DUR_MAX ||
      PED_WALK < 1 || PED_WALK > DUR_MAX) begin : g_bad_duration
    $error("traffic_phase_controller: phase duration outside 1..2**TIME_WIDTH");
  end

  localparam logic [TIME_WIDTH-1:0] LD_GREEN_NS = TIME_WIDTH'(GREEN_NS - 1);
  localparam logic [TIME_WIDTH-1:0] LD_GREEN_EW = TIME_WIDTH'(GREEN_EW - 1);
  localparam logic [TIME_WIDTH-1:0] LD_YELLOW   = TIME_WIDTH'(YELLOW - 1);
  localparam logic [TIME_WIDTH-1:0] LD_ALL_RED  = TIME_WIDTH'(ALL_RED - 1);
  localparam logic [TIME_WIDTH-1:0] LD_PED_WALK = TIME_WIDTH'(PED_WALK - 1);

  phase_e                state_q, state_d;
  logic                  car_q, car_d;
  logic                  ped_q, ped_d;
  lamps_t                lamps_q, lamps_d;
  logic                  expiry;
  logic                  load;
  logic [TIME_WIDTH-1:0] load_val;
  logic                  is_zero;

  phase_timer #(
    .TIME_WIDTH(TIME_WIDTH)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .load     (load),
    .load_val (load_val),
    .time_left(time_left),
    .is_zero  (is_zero)
  );

  assign expiry = en && is_zero;

  // Next phase, timer reload, request latches and lamp decode of the next phase
  always_comb begin
    state_d = state_q;
    if (expiry) begin
      case (state_q)
        NS_G:    if (car_q || ped_q) state_d = NS_Y;
        NS_Y:    state_d = RED_A;
        RED_A:   state_d = ped_q ? WALK : EW_G;
        WALK:    state_d = car_q ? EW_G : RED_B;
        EW_G:    state_d = EW_Y;
        EW_Y:    state_d = RED_B;
        RED_B:   state_d = NS_G;
        default: state_d = RED_B;
      endcase
    end

    load = (state_d != state_q);

    case (state_d)
      NS_G:       load_val = LD_GREEN_NS;
      NS_Y, EW_Y: load_val = LD_YELLOW;
      WALK:       load_val = LD_PED_WALK;
      EW_G:       load_val = LD_GREEN_EW;
      default:    load_val = LD_ALL_RED;
    endcase

    // Clear on the entering edge beats a same-cycle set
    car_d = (car_q || sensor_ew) && !(load && (state_d == EW_G));
    ped_d = (ped_q || ped_req)   && !(load && (state_d == WALK));

    lamps_d = lamp_decode(state_d);
  end

  // State, latches and registered lamp outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= RED_B;
      car_q        <= 1'b0;
      ped_q        <= 1'b0;
      lamps_q.ns   <= LAMP_R;
      lamps_q.ew   <= LAMP_R;
      lamps_q.walk <= 1'b0;
    end else begin
      state_q <= state_d;
      car_q   <= car_d;
      ped_q   <= ped_d;
      lamps_q <= lamps_d;
    end
  end

  assign light_ns    = lamps_q.ns;
  assign light_ew    = lamps_q.ew;
  assign walk        = lamps_q.walk;
  assign phase       = state_q;
  assign car_pending = car_q;
  assign ped_pending = ped_q;

endmodule
